// File: rtl/mem_refill_arbiter.sv
// Shares one word-wide memory port between Icache line refills and Dcache refill/write-back
// bursts. One line at a time, round-robin on contention, with Icache refill abort on redirect.
module mem_refill_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ic_req_i,
    input  logic [ADDR_W-1:0]             ic_addr_i,
    input  logic                          ic_abort_i,
    output logic                          ic_rvalid_o,
    output logic [DATA_W-1:0]             ic_rdata_o,
    output logic [$clog2(LINE_WORDS)-1:0] ic_word_idx_o,
    output logic                          ic_done_o,
    output logic                          ic_busy_o,
    input  logic                          dc_req_i,
    input  logic                          dc_we_i,
    input  logic [ADDR_W-1:0]             dc_addr_i,
    input  logic [DATA_W-1:0]             dc_wdata_i,
    output logic                          dc_rvalid_o,
    output logic [DATA_W-1:0]             dc_rdata_o,
    output logic [$clog2(LINE_WORDS)-1:0] dc_word_idx_o,
    output logic                          dc_done_o,
    output logic                          dc_busy_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    input  logic [DATA_W-1:0]             mem_rdata_i,
    input  logic                          mem_ready_i
);

    localparam int                IDX_W    = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IC_RD,
        S_DC_RD,
        S_DC_WR,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [IDX_W-1:0]  r_idx;
    logic [ADDR_W-1:0] r_base;
    logic              r_abort;
    logic              r_last_dc;   // owner of the latest grant; also tells DONE whom to notify

    logic w_grant_dc;
    logic w_grant_ic;
    logic w_in_burst;
    logic w_ic_kill;
    logic w_ic_rvalid;
    logic w_dc_rvalid;

    // Dcache wins contention unless it was the last one served.
    assign w_grant_dc  = dc_req_i & (~ic_req_i | ~r_last_dc);
    assign w_grant_ic  = ic_req_i & ~w_grant_dc;
    assign w_in_burst  = (r_state == S_IC_RD) | (r_state == S_DC_RD) | (r_state == S_DC_WR);
    assign w_ic_kill   = (r_state == S_IC_RD) & (r_abort | ic_abort_i);
    assign w_ic_rvalid = (r_state == S_IC_RD) & mem_ready_i & ~r_abort & ~ic_abort_i;
    assign w_dc_rvalid = (r_state == S_DC_RD) & mem_ready_i;

    // NOTE: sequential state uses <= so every register samples pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: each always_comb output gets a default first, so no branch can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_dc)      w_next_state = dc_we_i ? S_DC_WR : S_DC_RD;
                else if (w_grant_ic) w_next_state = S_IC_RD;
            end
            S_IC_RD, S_DC_RD, S_DC_WR: begin
                if (mem_ready_i) begin
                    if (w_ic_kill)               w_next_state = S_IDLE;
                    else if (r_idx == LAST_IDX)  w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_base    <= '0;
            r_abort   <= 1'b0;
            r_last_dc <= 1'b0;
        end else begin
            // Abort is remembered until the in-flight word completes; that completion exits.
            r_abort <= w_ic_kill & ~mem_ready_i;
            if (r_state == S_IDLE && (w_grant_dc || w_grant_ic)) begin
                r_base    <= (w_grant_dc ? dc_addr_i : ic_addr_i) & ~OFF_MASK;
                r_last_dc <= w_grant_dc;
                r_idx     <= '0;
            end else if (w_in_burst && mem_ready_i) begin
                r_idx <= w_ic_kill ? '0 : r_idx + 1'b1;
            end
        end
    end

    always_comb begin
        mem_req_o     = w_in_burst;
        mem_we_o      = (r_state == S_DC_WR);
        mem_addr_o    = w_in_burst ? r_base + ADDR_W'({r_idx, 2'b00}) : '0;
        mem_wdata_o   = (r_state == S_DC_WR) ? dc_wdata_i : '0;
        ic_rvalid_o   = w_ic_rvalid;
        ic_rdata_o    = w_ic_rvalid ? mem_rdata_i : '0;
        ic_word_idx_o = (r_state == S_IC_RD) ? r_idx : '0;
        ic_done_o     = (r_state == S_DONE) & ~r_last_dc;
        ic_busy_o     = ic_req_i | (r_state == S_IC_RD) | ((r_state == S_DONE) & ~r_last_dc);
        dc_rvalid_o   = w_dc_rvalid;
        dc_rdata_o    = w_dc_rvalid ? mem_rdata_i : '0;
        dc_word_idx_o = ((r_state == S_DC_RD) || (r_state == S_DC_WR)) ? r_idx : '0;
        dc_done_o     = (r_state == S_DONE) & r_last_dc;
        dc_busy_o     = dc_req_i | (r_state == S_DC_RD) | (r_state == S_DC_WR)
                      | ((r_state == S_DONE) & r_last_dc);
    end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Bench for mem_refill_arbiter: directed cases then random bursts, each checked against a
// line/word-level model of grants, addresses, data and done/abort behaviour.
module tb_mem_refill_arbiter;

    localparam int LINE_WORDS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_req_i, ic_abort_i;
    logic [31:0] ic_addr_i;
    logic        ic_rvalid_o, ic_done_o, ic_busy_o;
    logic [31:0] ic_rdata_o;
    logic [1:0]  ic_word_idx_o;
    logic        dc_req_i, dc_we_i;
    logic [31:0] dc_addr_i, dc_wdata_i;
    logic        dc_rvalid_o, dc_done_o, dc_busy_o;
    logic [31:0] dc_rdata_o;
    logic [1:0]  dc_word_idx_o;
    logic        mem_req_o, mem_we_o, mem_ready_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   m_prefer_dc;          // model: who wins the next simultaneous request
    logic [31:0] wb_base;       // Dcache write-back line contents are wb_base + word index

    assign dc_wdata_i = wb_base + 32'(dc_word_idx_o);

    mem_refill_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(LINE_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_abort_i(ic_abort_i),
        .ic_rvalid_o(ic_rvalid_o), .ic_rdata_o(ic_rdata_o), .ic_word_idx_o(ic_word_idx_o),
        .ic_done_o(ic_done_o), .ic_busy_o(ic_busy_o),
        .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
        .dc_rvalid_o(dc_rvalid_o), .dc_rdata_o(dc_rdata_o), .dc_word_idx_o(dc_word_idx_o),
        .dc_done_o(dc_done_o), .dc_busy_o(dc_busy_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Entered mid-cycle with the arbiter idle and the request visible; returns mid-cycle in
    // the idle cycle that follows the burst.
    task automatic serve(input bit is_ic, input logic [31:0] addr, input bit we,
                         input int ab_w, input bit ab_c, input int gap_fix, input bit raise_other);
        logic [31:0] base, rd;
        int          gap;
        bit          killed;
        killed = 1'b0;
        base   = addr - (addr % (LINE_WORDS * 4));
        m_prefer_dc = is_ic;

        @(negedge clk);
        chk1("grant_wait_req", mem_req_o, 1'b0);
        chk1("grant_wait_ic_done", ic_done_o, 1'b0);
        chk1("grant_wait_dc_done", dc_done_o, 1'b0);
        chk1("grant_wait_busy", is_ic ? ic_busy_o : dc_busy_o, 1'b1);
        tick();

        // The request inputs are now free to change; only the granted values may matter.
        if (is_ic) ic_addr_i = $urandom;
        else begin
            dc_addr_i = $urandom;
            dc_we_i   = ~we;
        end
        if (raise_other) begin
            if (is_ic) dc_req_i = 1'b1;
            else       ic_req_i = 1'b1;
        end

        for (int w = 0; w < LINE_WORDS; w++) begin
            gap = (gap_fix >= 0) ? gap_fix : int'($urandom_range(0, 2));
            if (is_ic && w == ab_w && !ab_c && gap == 0) gap = 1;
            for (int g = 0; g < gap; g++) begin
                if (is_ic) ic_abort_i = (w == ab_w && !ab_c && g == 0);
                else       ic_abort_i = 1'($urandom_range(0, 1));
                if (is_ic && ic_abort_i) killed = 1'b1;
                @(negedge clk);
                chk1("wait_mem_req", mem_req_o, 1'b1);
                chk("wait_mem_addr", mem_addr_o, base + 32'(4 * w));
                chk1("wait_mem_we", mem_we_o, we);
                chk1("wait_rvalid", is_ic ? ic_rvalid_o : dc_rvalid_o, 1'b0);
                tick();
            end
            if (is_ic) ic_abort_i = (w == ab_w && ab_c);
            else       ic_abort_i = 1'($urandom_range(0, 1));
            if (is_ic && ic_abort_i) killed = 1'b1;
            rd          = $urandom;
            mem_rdata_i = rd;
            mem_ready_i = 1'b1;
            @(negedge clk);
            chk1("word_mem_req", mem_req_o, 1'b1);
            chk("word_mem_addr", mem_addr_o, base + 32'(4 * w));
            chk1("word_mem_we", mem_we_o, we);
            chk1("word_busy", is_ic ? ic_busy_o : dc_busy_o, 1'b1);
            if (is_ic) begin
                chk1("ic_rvalid", ic_rvalid_o, !killed);
                chk1("dc_rvalid_in_ic", dc_rvalid_o, 1'b0);
                if (!killed) begin
                    chk("ic_rdata", ic_rdata_o, rd);
                    chk("ic_word_idx", 32'(ic_word_idx_o), 32'(w));
                end
            end else begin
                chk1("dc_rvalid", dc_rvalid_o, !we);
                chk1("ic_rvalid_in_dc", ic_rvalid_o, 1'b0);
                chk("dc_word_idx", 32'(dc_word_idx_o), 32'(w));
                if (we) chk("mem_wdata", mem_wdata_o, wb_base + 32'(w));
                else    chk("dc_rdata", dc_rdata_o, rd);
            end
            tick();
            mem_ready_i = 1'b0;
            ic_abort_i  = 1'b0;
            if (killed) break;
        end

        if (killed) begin
            ic_req_i = 1'b0;
        end else begin
            if (is_ic) ic_req_i = 1'b0;
            else       dc_req_i = 1'b0;
            @(negedge clk);
            chk1("done_side", is_ic ? ic_done_o : dc_done_o, 1'b1);
            chk1("done_other", is_ic ? dc_done_o : ic_done_o, 1'b0);
            chk1("done_mem_req", mem_req_o, 1'b0);
            chk1("done_busy", is_ic ? ic_busy_o : dc_busy_o, 1'b1);
            tick();
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk1("idle_mem_req", mem_req_o, 1'b0);
        chk1("idle_ic_done", ic_done_o, 1'b0);
        chk1("idle_dc_done", dc_done_o, 1'b0);
        chk1("idle_ic_busy", ic_busy_o, 1'b0);
        chk1("idle_dc_busy", dc_busy_o, 1'b0);
        tick();
    endtask

    // One arbitration round: both requesters (if any) are served in model-predicted order.
    task automatic round(input bit want_ic, input bit want_dc, input bit late_other,
                         input int ab_w, input bit ab_c, input int gap);
        logic [31:0] ia, da;
        bit          dwe, first_ic, two;
        ia       = ic_addr_i;
        da       = dc_addr_i;
        dwe      = dc_we_i;
        first_ic = (want_ic && want_dc) ? !m_prefer_dc : want_ic;
        two      = (want_ic && want_dc) || late_other;
        ic_req_i = want_ic;
        dc_req_i = want_dc;
        if (first_ic) serve(1'b1, ia, 1'b0, ab_w, ab_c, gap, late_other);
        else          serve(1'b0, da, dwe, -1, 1'b0, gap, late_other);
        if (two) begin
            if (first_ic) serve(1'b0, da, dwe, -1, 1'b0, gap, 1'b0);
            else          serve(1'b1, ia, 1'b0, ab_w, ab_c, gap, 1'b0);
        end
        idle_check();
    endtask

    initial begin
        rst_n       = 1'b0;
        ic_req_i    = 1'b0;
        ic_abort_i  = 1'b0;
        ic_addr_i   = '0;
        dc_req_i    = 1'b0;
        dc_we_i     = 1'b0;
        dc_addr_i   = '0;
        mem_ready_i = 1'b0;
        mem_rdata_i = 32'hDEAD_BEEF;
        wb_base     = '0;
        m_prefer_dc = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_zero", 32'(|{mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}), 32'd0);
        chk("reset_ic_zero", 32'(|{ic_rvalid_o, ic_rdata_o, ic_word_idx_o, ic_done_o, ic_busy_o}), 32'd0);
        chk("reset_dc_zero", 32'(|{dc_rvalid_o, dc_rdata_o, dc_word_idx_o, dc_done_o, dc_busy_o}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Simultaneous requests after reset: Dcache first, then alternate.
        ic_addr_i = 32'h0000_2000;
        dc_addr_i = 32'h0000_3004;
        dc_we_i   = 1'b0;
        round(1'b1, 1'b1, 1'b0, -1, 1'b0, -1);
        round(1'b1, 1'b1, 1'b0, -1, 1'b0, -1);

        // Icache refill, ready every second cycle.
        ic_addr_i = 32'h0000_1234;
        round(1'b1, 1'b0, 1'b0, -1, 1'b0, 1);
        ic_addr_i = 32'h0000_2040;
        dc_addr_i = 32'h0000_30F8;
        round(1'b1, 1'b1, 1'b0, -1, 1'b0, 0);

        // Dcache write-back of 0xA0..0xA3.
        dc_addr_i = 32'h8000_0010;
        dc_we_i   = 1'b1;
        wb_base   = 32'h0000_00A0;
        round(1'b0, 1'b1, 1'b0, -1, 1'b0, -1);

        // Abort after word 1, ready three cycles later; Dcache request arrives mid-burst.
        ic_addr_i = 32'h0000_5000;
        dc_addr_i = 32'h0000_6000;
        dc_we_i   = 1'b0;
        round(1'b1, 1'b0, 1'b1, 2, 1'b0, 3);

        // Abort coinciding with the first returned word.
        ic_addr_i = 32'h0000_7008;
        round(1'b1, 1'b0, 1'b0, 0, 1'b1, 1);

        // Reset in the middle of a Dcache refill, at word 2.
        dc_addr_i = 32'h0000_4048;
        dc_we_i   = 1'b0;
        dc_req_i  = 1'b1;
        tick();
        repeat (2) begin
            mem_ready_i = 1'b1;
            mem_rdata_i = $urandom;
            tick();
        end
        mem_ready_i = 1'b0;
        @(negedge clk);
        chk("pre_reset_idx", 32'(dc_word_idx_o), 32'd2);
        chk("pre_reset_addr", mem_addr_o, 32'h0000_4048);
        tick();
        rst_n    = 1'b0;
        dc_req_i = 1'b0;
        #1;
        chk("midrst_mem_zero", 32'(|{mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}), 32'd0);
        chk("midrst_ic_zero", 32'(|{ic_rvalid_o, ic_rdata_o, ic_word_idx_o, ic_done_o, ic_busy_o}), 32'd0);
        chk("midrst_dc_zero", 32'(|{dc_rvalid_o, dc_rdata_o, dc_word_idx_o, dc_done_o, dc_busy_o}), 32'd0);
        tick();
        rst_n       = 1'b1;
        m_prefer_dc = 1'b1;
        tick();
        dc_addr_i = 32'h0000_4048;
        round(1'b0, 1'b1, 1'b0, -1, 1'b0, -1);

        for (int it = 0; it < 30; it++) begin
            int kind;
            int abw;
            kind      = int'($urandom_range(0, 2));
            ic_addr_i = $urandom;
            dc_addr_i = $urandom;
            dc_we_i   = 1'($urandom_range(0, 1));
            wb_base   = $urandom;
            abw       = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, LINE_WORDS - 1)) : -1;
            round(kind != 1, kind != 0, 1'($urandom_range(0, 1)), abw, 1'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
